byte_lane_dly_seq: RTL and testbench

Delay-programming sequencer for one or more byte lanes.
- Holds a shadow copy of every IDELAY/ODELAY value per lane and accepts host writes at any time.
- On a commit request, walks all delay addresses, issuing per-lane load strobes for changed (or all) entries, then one common set strobe.
- Sits between the PHY control register interface and the byte lanes' dly_data/dly_addr/ld_delay/set inputs, in the clk_div domain.

---
 rtl/phy_dly_pkg.sv | 32 +++
 rtl/dly_shadow_ram.sv | 76 +++++++
 rtl/byte_lane_dly_seq.sv | 157 +++++++++++++++
 tb/tb_byte_lane_dly_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_dly_pkg.sv
// Shared constants, address mapping helpers and sequencer state type for the
// byte-lane delay programming path.
package phy_dly_pkg;

  localparam int NUM_DLY_ENTRIES = 19;
  localparam int DLY_ADDR_W      = 5;
  localparam int DLY_W           = 8;
  localparam int DLY_IDX_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SET
  } seq_state_e;

  // Addresses 0..9 are output delays, 16..24 are input delays; 10..15 and
  // 25..31 are holes in the map.
  function automatic logic addr_valid(input logic [DLY_ADDR_W-1:0] addr);
    return (addr <= 5'd9) || ((addr >= 5'd16) && (addr <= 5'd24));
  endfunction

  // Compacts the sparse address map into a dense 0..18 entry index.
  function automatic logic [DLY_IDX_W-1:0] addr2idx(input logic [DLY_ADDR_W-1:0] addr);
    return (addr <= 5'd9) ? addr : (addr - 5'd6);
  endfunction

  // Expands a dense entry index back to the lane-side delay address.
  function automatic logic [DLY_ADDR_W-1:0] idx2addr(input logic [DLY_IDX_W-1:0] idx);
    return (idx <= 5'd9) ? idx : (idx + 5'd6);
  endfunction

endpackage

// File: rtl/dly_shadow_ram.sv
// Per-lane shadow copy of every delay entry with a dirty bit per entry.
// Host writes always beat a same-cycle dirty clear from the sequencer.
module dly_shadow_ram
  import phy_dly_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic                         clk_div_i,
  input  logic                         rst_n_i,
  input  logic                         wr_en_i,
  input  logic [2:0]                   wr_lane_i,
  input  logic [DLY_IDX_W-1:0]         wr_idx_i,
  input  logic [DLY_W-1:0]             wr_data_i,
  input  logic [2:0]                   rd_lane_i,
  input  logic [DLY_IDX_W-1:0]         rd_idx_i,
  output logic [DLY_W-1:0]             rd_data_o,
  input  logic [DLY_IDX_W-1:0]         seq_idx_i,
  output logic [DLY_W*NUM_LANES-1:0]   seq_data_o,
  output logic [NUM_LANES-1:0]         seq_dirty_o,
  input  logic                         clr_en_i,
  input  logic [NUM_LANES-1:0]         clr_mask_i
);

  logic [DLY_W-1:0]           entry_q [NUM_LANES][NUM_DLY_ENTRIES];
  logic [NUM_DLY_ENTRIES-1:0] dirty_q [NUM_LANES];

  // Entry and dirty storage: reset to zero/all-dirty, write has priority over clear.
  always_ff @(posedge clk_div_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        dirty_q[l] <= '1;
        for (int e = 0; e < NUM_DLY_ENTRIES; e++) begin
          entry_q[l][e] <= '0;
        end
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int e = 0; e < NUM_DLY_ENTRIES; e++) begin
          if (wr_en_i && (wr_lane_i == 3'(l)) && (wr_idx_i == DLY_IDX_W'(e))) begin
            entry_q[l][e] <= wr_data_i;
            dirty_q[l][e] <= 1'b1;
          end else if (clr_en_i && clr_mask_i[l] && (seq_idx_i == DLY_IDX_W'(e))) begin
            dirty_q[l][e] <= 1'b0;
          end
        end
      end
    end
  end

  // Host readback mux; out-of-range lane or index reads as zero.
  always_comb begin
    rd_data_o = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int e = 0; e < NUM_DLY_ENTRIES; e++) begin
        if ((rd_lane_i == 3'(l)) && (rd_idx_i == DLY_IDX_W'(e))) begin
          rd_data_o = entry_q[l][e];
        end
      end
    end
  end

  // Sequencer read port: one index across all lanes at once.
  always_comb begin
    seq_data_o  = '0;
    seq_dirty_o = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int e = 0; e < NUM_DLY_ENTRIES; e++) begin
        if (seq_idx_i == DLY_IDX_W'(e)) begin
          seq_data_o[l*DLY_W +: DLY_W] = entry_q[l][e];
          seq_dirty_o[l]               = dirty_q[l][e];
        end
      end
    end
  end

endmodule

// File: rtl/byte_lane_dly_seq.sv
// Delay-programming sequencer: shadows per-lane delay values and, on commit,
// walks every entry issuing per-lane load strobes followed by one set strobe.
module byte_lane_dly_seq
  import phy_dly_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic                         clk_div_i,
  input  logic                         rst_n_i,
  input  logic                         wr_en_i,
  input  logic [2:0]                   wr_lane_i,
  input  logic [DLY_ADDR_W-1:0]        wr_addr_i,
  input  logic [DLY_W-1:0]             wr_data_i,
  output logic                         wr_err_o,
  input  logic [2:0]                   rd_lane_i,
  input  logic [DLY_ADDR_W-1:0]        rd_addr_i,
  output logic [DLY_W-1:0]             rd_data_o,
  input  logic                         commit_i,
  input  logic                         force_all_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [DLY_ADDR_W-1:0]        dly_addr_o,
  output logic [DLY_W*NUM_LANES-1:0]   dly_data_o,
  output logic [NUM_LANES-1:0]         ld_delay_o,
  output logic                         set_o
);

  seq_state_e                 state_q, state_d;
  logic [DLY_IDX_W-1:0]       idx_q, idx_d;
  logic                       force_q, force_d;
  logic                       pending_q, pending_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       set_q, set_d;
  logic                       wr_err_q, wr_err_d;
  logic [DLY_ADDR_W-1:0]      dly_addr_q, dly_addr_d;
  logic [DLY_W*NUM_LANES-1:0] dly_data_q, dly_data_d;
  logic [NUM_LANES-1:0]       ld_q, ld_d;

  logic                       laneOk;
  logic                       wrValid;
  logic                       clrEn;
  logic [DLY_W-1:0]           ramRdData;
  logic [DLY_W*NUM_LANES-1:0] seqData;
  logic [NUM_LANES-1:0]       seqDirty;

  assign laneOk   = ({29'd0, wr_lane_i} < 32'(NUM_LANES));
  assign wrValid  = wr_en_i && laneOk && addr_valid(wr_addr_i);
  assign wr_err_d = wr_en_i && !wrValid;
  assign clrEn    = (state_d == ST_LOAD);

  // The RAM is read at the index about to be presented, so the output
  // registers capture it on the same edge that clears its dirty bits.
  dly_shadow_ram #(
    .NUM_LANES (NUM_LANES)
  ) u_shadow (
    .clk_div_i   (clk_div_i),
    .rst_n_i     (rst_n_i),
    .wr_en_i     (wrValid),
    .wr_lane_i   (wr_lane_i),
    .wr_idx_i    (addr2idx(wr_addr_i)),
    .wr_data_i   (wr_data_i),
    .rd_lane_i   (rd_lane_i),
    .rd_idx_i    (addr2idx(rd_addr_i)),
    .rd_data_o   (ramRdData),
    .seq_idx_i   (idx_d),
    .seq_data_o  (seqData),
    .seq_dirty_o (seqDirty),
    .clr_en_i    (clrEn),
    .clr_mask_i  (ld_d)
  );

  assign rd_data_o = addr_valid(rd_addr_i) ? ramRdData : '0;

  // Next-state logic: IDLE accepts a commit or a pending one, LOAD walks 19 indices, SET is one cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = '0;
    force_d   = force_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_i || pending_q) begin
          state_d   = ST_LOAD;
          force_d   = force_all_i;
          pending_d = 1'b0;
        end
      end
      ST_LOAD: begin
        pending_d = pending_q | commit_i;
        if (idx_q == DLY_IDX_W'(NUM_DLY_ENTRIES - 1)) begin
          state_d = ST_SET;
        end else begin
          idx_d = idx_q + DLY_IDX_W'(1);
        end
      end
      ST_SET: begin
        pending_d = pending_q | commit_i;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the cycle after the next edge, derived from the next state.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_q == ST_SET);
    set_d      = (state_d == ST_SET);
    dly_addr_d = '0;
    dly_data_d = '0;
    ld_d       = '0;
    if (state_d == ST_LOAD) begin
      dly_addr_d = idx2addr(idx_d);
      dly_data_d = seqData;
      ld_d       = seqDirty | {NUM_LANES{force_d}};
    end
  end

  // Sequencer state, index, latches and registered outputs; reset aborts any pass.
  always_ff @(posedge clk_div_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      force_q    <= 1'b0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      set_q      <= 1'b0;
      wr_err_q   <= 1'b0;
      dly_addr_q <= '0;
      dly_data_q <= '0;
      ld_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      force_q    <= force_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      set_q      <= set_d;
      wr_err_q   <= wr_err_d;
      dly_addr_q <= dly_addr_d;
      dly_data_q <= dly_data_d;
      ld_q       <= ld_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign set_o      = set_q;
  assign wr_err_o   = wr_err_q;
  assign dly_addr_o = dly_addr_q;
  assign dly_data_o = dly_data_q;
  assign ld_delay_o = ld_q;

endmodule

// File: tb/tb_byte_lane_dly_seq.sv
// Scoreboard bench for byte_lane_dly_seq with two lanes.
module tb_byte_lane_dly_seq;

  localparam int NL = 2;
  localparam int NE = 19;

  logic          clk      = 1'b0;
  logic          rstN     = 1'b1;
  logic          wrEn     = 1'b0;
  logic [2:0]    wrLane   = '0;
  logic [4:0]    wrAddr   = '0;
  logic [7:0]    wrData   = '0;
  logic          wrErr;
  logic [2:0]    rdLane   = '0;
  logic [4:0]    rdAddr   = '0;
  logic [7:0]    rdData;
  logic          commit   = 1'b0;
  logic          forceAll = 1'b0;
  logic          busy;
  logic          done;
  logic          setO;
  logic [4:0]    dlyAddr;
  logic [8*NL-1:0] dlyData;
  logic [NL-1:0] ldDelay;

  typedef struct {
    int          cyc;
    logic [25:0] vec;
  } passRec_t;

  typedef struct {
    int   cyc;
    logic err;
  } errRec_t;

  passRec_t passQ[$];
  errRec_t  errQ[$];

  logic [7:0] modelEntry [NL][NE];
  logic       modelDirty [NL][NE];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int t;

  byte_lane_dly_seq #(
    .NUM_LANES (NL)
  ) dut (
    .clk_div_i   (clk),
    .rst_n_i     (rstN),
    .wr_en_i     (wrEn),
    .wr_lane_i   (wrLane),
    .wr_addr_i   (wrAddr),
    .wr_data_i   (wrData),
    .wr_err_o    (wrErr),
    .rd_lane_i   (rdLane),
    .rd_addr_i   (rdAddr),
    .rd_data_o   (rdData),
    .commit_i    (commit),
    .force_all_i (forceAll),
    .busy_o      (busy),
    .done_o      (done),
    .dly_addr_o  (dlyAddr),
    .dly_data_o  (dlyData),
    .ld_delay_o  (ldDelay),
    .set_o       (setO)
  );

  // Free-running half-rate clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int idxToAddr(input int k);
    return (k < 10) ? k : k + 6;
  endfunction

  function automatic int addrToIdx(input int a);
    return (a < 10) ? a : a - 6;
  endfunction

  task automatic resetModel();
    for (int l = 0; l < NL; l++) begin
      for (int e = 0; e < NE; e++) begin
        modelEntry[l][e] = 8'h00;
        modelDirty[l][e] = 1'b1;
      end
    end
  endtask

  // Expected outputs for a full pass whose accept edge is t.
  task automatic pushPass(input logic frc, input int tStart);
    passRec_t        r;
    logic [NL-1:0]   ld;
    logic [8*NL-1:0] data;
    logic [8*NL-1:0] dataZ;
    dataZ = '0;
    for (int k = 0; k < NE; k++) begin
      for (int l = 0; l < NL; l++) begin
        ld[l]          = modelDirty[l][k] | frc;
        data[l*8 +: 8] = modelEntry[l][k];
        if (ld[l]) modelDirty[l][k] = 1'b0;
      end
      r.cyc = tStart + k;
      r.vec = {5'(idxToAddr(k)), data, ld, 1'b0, 1'b1, 1'b0};
      passQ.push_back(r);
    end
    r.cyc = tStart + 19;
    r.vec = {5'd0, dataZ, 2'b00, 1'b1, 1'b1, 1'b0};
    passQ.push_back(r);
    r.cyc = tStart + 20;
    r.vec = {5'd0, dataZ, 2'b00, 1'b0, 1'b0, 1'b1};
    passQ.push_back(r);
  endtask

  // One-cycle host write with its expected wr_err response.
  task automatic applyStimulus(input int lane, input int addr, input logic [7:0] data, input logic expErr);
    errRec_t e;
    wrEn   = 1'b1;
    wrLane = 3'(lane);
    wrAddr = 5'(addr);
    wrData = data;
    e.cyc  = cyc + 1;
    e.err  = expErr;
    errQ.push_back(e);
    if (!expErr) begin
      modelEntry[lane][addrToIdx(addr)] = data;
      modelDirty[lane][addrToIdx(addr)] = 1'b1;
    end
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic issueCommit(input logic frc, output int tAcc);
    tAcc     = cyc + 1;
    commit   = 1'b1;
    forceAll = frc;
    pushPass(frc, tAcc);
    @(negedge clk);
    commit   = 1'b0;
    forceAll = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (passQ.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (passQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL pass timeout: actual=%0d records left required=0", passQ.size());
      passQ.delete();
    end
  endtask

  task automatic checkRead(input int lane, input int addr, input logic [7:0] exp);
    rdLane = 3'(lane);
    rdAddr = 5'(addr);
    #1;
    checkOutput($sformatf("rd lane%0d addr%0d", lane, addr), {24'd0, rdData}, {24'd0, exp});
  endtask

  // Monitor: pops expected records as their cycle arrives and flags stray activity.
  initial begin : monitor
    passRec_t    pr;
    errRec_t     er;
    logic [25:0] act;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (errQ.size() > 0 && errQ[0].cyc <= cyc) begin
        er = errQ.pop_front();
        checkOutput($sformatf("wr_err@%0d", er.cyc), {31'd0, wrErr}, {31'd0, er.err});
      end else if (wrErr) begin
        checkOutput($sformatf("stray wr_err@%0d", cyc), {31'd0, wrErr}, 32'd0);
      end
      act = {dlyAddr, dlyData, ldDelay, setO, busy, done};
      if (passQ.size() > 0 && passQ[0].cyc <= cyc) begin
        pr = passQ.pop_front();
        checkOutput($sformatf("pass@%0d {addr,data,ld,set,busy,done}", pr.cyc), {6'd0, act}, {6'd0, pr.vec});
      end else if (act != 26'd0) begin
        checkOutput($sformatf("stray pass output@%0d", cyc), {6'd0, act}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    #1 rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy",     {31'd0, busy},    32'd0);
    checkOutput("reset done",     {31'd0, done},    32'd0);
    checkOutput("reset set",      {31'd0, setO},    32'd0);
    checkOutput("reset ld_delay", {30'd0, ldDelay}, 32'd0);
    checkOutput("reset dly_addr", {27'd0, dlyAddr}, 32'd0);
    checkOutput("reset dly_data", {16'd0, dlyData}, 32'd0);
    checkOutput("reset wr_err",   {31'd0, wrErr},   32'd0);
    rstN = 1'b1;
    resetModel();
    @(negedge clk);

    $display("[TB] pass after reset: every entry dirty");
    issueCommit(1'b0, t);
    waitIdle();

    $display("[TB] single write lane1 addr17");
    applyStimulus(1, 17, 8'h5A, 1'b0);
    checkRead(1, 17, 8'h5A);
    issueCommit(1'b0, t);
    waitIdle();

    $display("[TB] invalid writes");
    applyStimulus(0, 12, 8'h77, 1'b1);
    applyStimulus(1, 15, 8'hFF, 1'b1);
    applyStimulus(3, 0, 8'h44, 1'b1);
    @(negedge clk);
    checkRead(1, 15, 8'h00);
    checkRead(3, 0, 8'h00);
    checkRead(0, 12, 8'h00);
    checkRead(1, 17, 8'h5A);
    issueCommit(1'b0, t);
    waitIdle();

    $display("[TB] write colliding with load, plus pending commit");
    applyStimulus(0, 3, 8'h22, 1'b0);
    issueCommit(1'b0, t);
    while (cyc < t + 3) @(negedge clk);
    commit = 1'b1;
    applyStimulus(0, 3, 8'h33, 1'b0);
    commit = 1'b0;
    pushPass(1'b0, t + 21);
    waitIdle();
    checkRead(0, 3, 8'h33);

    $display("[TB] clean shadow with and without force_all");
    issueCommit(1'b1, t);
    waitIdle();
    issueCommit(1'b0, t);
    waitIdle();

    $display("[TB] reset mid-pass");
    issueCommit(1'b0, t);
    while (cyc < t + 9) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abort busy",     {31'd0, busy},    32'd0);
    checkOutput("abort ld_delay", {30'd0, ldDelay}, 32'd0);
    checkOutput("abort dly_addr", {27'd0, dlyAddr}, 32'd0);
    checkOutput("abort dly_data", {16'd0, dlyData}, 32'd0);
    checkOutput("abort set",      {31'd0, setO},    32'd0);
    passQ.delete();
    resetModel();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    checkRead(1, 17, 8'h00);
    checkRead(0, 3, 8'h00);
    @(negedge clk);
    issueCommit(1'b0, t);
    waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(passQ.size() + errQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
